placement_registry: RTL and testbench
=====================================

// Module: placement_registry
// PURPOSE
//  Responder side of the setup collision/placement interface. Stores nest and sugar-patch
//  coordinates committed during SETUP_MODE and answers collide_x/collide_y queries with a
//  same-cycle collision flag. Exports the packed nests_X/nests_Y tables to the ants.
//  Sits between the setup sequencer and the ant/patch datapaths; frozen once SETUP_MODE drops.
// PARAMETERS
//  NEST_R    2  Chebyshev exclusion radius (pixels) around each valid nest
//  PATCH_R   3  Chebyshev exclusion radius (pixels) around each valid sugar patch
//  (NEST_num, SUGARPATCH_num, X_bits, Y_bits, *_num_bits, PIXELS_X/Y come from the shared package.)
// PORTS
//  setup_clk      in   1                  single clock
//  RESET_SIM_n    in   1                  async active-low reset
//  SETUP_MODE     in   1                  1 = registry writable; 1->0 edge locks the tables
//  nest_wr        in   1                  commit strobe: nest_id slot <= (nest_setup_x, nest_setup_y)
//  nest_id        in   NEST_num_bits      nest slot index
//  nest_setup_x   in   X_bits             nest X
//  nest_setup_y   in   Y_bits             nest Y
//  patch_wr       in   1                  commit strobe for patch slot
//  patch_id       in   SUGARPATCH_num_bits  patch slot index
//  patch_setup_x  in   X_bits             patch X
//  patch_setup_y  in   Y_bits             patch Y
//  collide_x      in   X_bits             query X
//  collide_y      in   Y_bits             query Y
//  collision      out  1                  combinational: query inside any valid exclusion box
//  nests_X        out  NEST_num*X_bits    packed [NEST_num-1:0][X_bits-1:0]; invalid slot = 0
//  nests_Y        out  NEST_num*Y_bits    packed [NEST_num-1:0][Y_bits-1:0]; invalid slot = 0
//  nest_count     out  NEST_num_bits+1    number of valid nest slots
//  patch_count    out  SUGARPATCH_num_bits+1  number of valid patch slots
//  tables_full    out  1                  all nest AND all patch slots valid
//  locked         out  1                  registry in LOCKED state
//  err_o          out  3                  sticky {late_write, bad_index, dup_write}
// BEHAVIOUR
//  Reset (RESET_SIM_n=0, async): all valid bits, coordinates, counts, err_o cleared;
//    state=FILL; collision=0, nests_X/Y=0, tables_full=0, locked=0.
//  FSM: FILL -> LOCKED on a registered SETUP_MODE 1->0 edge. LOCKED persists until reset;
//    SETUP_MODE returning to 1 does not reopen.
//  Write (FILL only): on posedge with *_wr=1, id < *_num, and slot not yet valid, store coords,
//    set valid, count+1. Visible on the next cycle.
//    id >= *_num -> ignored, err_o[1] set.
//    Slot already valid -> ignored (first write wins), err_o[0] set.
//    Any *_wr in LOCKED -> ignored, err_o[2] set.
//  nest_wr and patch_wr in the same cycle are both legal and independent.
//  Query: collision = OR over valid nests of (|qx-nx|<=NEST_R && |qy-ny|<=NEST_R)
//    OR over valid patches with PATCH_R. Differences are computed unsigned-safe,
//    one bit wider than X_bits/Y_bits; no wrap at screen edges.
//    Query also returns 1 if collide_x>=PIXELS_X or collide_y>=PIXELS_Y.
//    Query uses registered table only, with no same-cycle write bypass: a candidate committed
//    this cycle does not collide with itself.
//  Latency: write -> collision/nests_X visible 1 cycle later; query -> collision 0 cycles.
//  Reset asserted mid-fill discards all entries; no partial state survives.
// STRUCTURE
//  Package (shared): NEST_num, SUGARPATCH_num, X_bits, Y_bits, *_num_bits, PIXELS_X/Y,
//    typedef struct packed {logic v; logic [X_bits-1:0] x; logic [Y_bits-1:0] y;} loc_entry_t.
//  Sub-module: loc_table #(N, IDW, R): valid/coord storage, write/error logic, per-table hit
//    reduction. Instantiated twice (nests R=NEST_R, patches R=PATCH_R).
//    The top level holds the FSM, error ORing, and output packing.
// TESTING
//  1. Reset, query (10,10) -> collision=0; nest_wr id0 (10,10); next cycle query (12,8) -> 1,
//     query (13,10) -> 0, nests_X[0]=10, nest_count=1.
//  2. Patch id1 at (50,40): query (53,43) -> 1, (54,40) -> 0; patch_count=1, nest tables unchanged.
//  3. nest_wr id0 again with (90,90) -> nests_X[0] stays 10, err_o=3'b001;
//     nest_wr id=NEST_num -> err_o=3'b011.
//  4. Fill all slots, then drop SETUP_MODE -> tables_full=1, locked=1 next cycle;
//     further patch_wr -> table unchanged, err_o[2]=1.
//  5. Same-cycle nest_wr id2 (30,30) with query (30,30) -> collision=0 this cycle, 1 next cycle.
//  6. Pulse RESET_SIM_n low mid-fill -> collision, counts, nests_X/Y, err_o all 0 immediately
//     (async); state=FILL.

Source files
------------

// File: rtl/placement_registry_pkg.sv
// Shared sizing, entry layout and helpers for the nest/sugar-patch placement registry.
package placement_registry_pkg;

    localparam int NEST_num            = 3;
    localparam int SUGARPATCH_num      = 3;
    localparam int NEST_num_bits       = 2;
    localparam int SUGARPATCH_num_bits = 2;
    localparam int X_bits              = 8;
    localparam int Y_bits              = 8;
    localparam int PIXELS_X            = 160;
    localparam int PIXELS_Y            = 120;

    typedef struct packed {
        logic              v;
        logic [X_bits-1:0] x;
        logic [Y_bits-1:0] y;
    } loc_entry_t;

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_LOCKED = 1'b1
    } reg_state_t;

    // Distances are one bit wider than the coordinate so they never wrap.
    function automatic logic [X_bits:0] abs_diff_x(input logic [X_bits-1:0] a,
                                                   input logic [X_bits-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    function automatic logic [Y_bits:0] abs_diff_y(input logic [Y_bits-1:0] a,
                                                   input logic [Y_bits-1:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

endpackage

// File: rtl/placement_registry_loc_table.sv
// One location table: first-write-wins slot storage, per-write error pulses and
// a combinational Chebyshev-box hit against the registered entries.
module placement_registry_loc_table
    import placement_registry_pkg::*;
#(
    parameter int N   = 3,
    parameter int IDW = 2,
    parameter int R   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_lock,
    input  logic                  i_wr,
    input  logic [IDW-1:0]        i_id,
    input  logic [X_bits-1:0]     i_x,
    input  logic [Y_bits-1:0]     i_y,
    input  logic [X_bits-1:0]     i_qx,
    input  logic [Y_bits-1:0]     i_qy,
    output logic                  o_hit,
    output loc_entry_t [N-1:0]    o_entries,
    output logic [IDW:0]          o_count,
    output logic [2:0]            o_err
);

    localparam logic [IDW:0]    LP_N  = (IDW+1)'(N);
    localparam logic [X_bits:0] LP_RX = (X_bits+1)'(R);
    localparam logic [Y_bits:0] LP_RY = (Y_bits+1)'(R);

    loc_entry_t     r_entries [N];
    logic [IDW:0]   r_count;
    logic [N-1:0]   w_sel;
    logic [N-1:0]   w_valid;
    logic [N-1:0]   w_hit;
    logic           w_id_ok;
    logic           w_taken;
    logic           w_accept;

    assign w_id_ok  = ({1'b0, i_id} < LP_N);
    assign w_taken  = |(w_sel & w_valid);
    assign w_accept = i_wr & ~i_lock & w_id_ok & ~w_taken;

    // {late, bad_index, dup}; a locked table reports only the late write.
    assign o_err = {i_wr & i_lock,
                    i_wr & ~i_lock & ~w_id_ok,
                    i_wr & ~i_lock & w_id_ok & w_taken};

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            assign w_sel[gi]     = ({1'b0, i_id} == (IDW+1)'(gi));
            assign w_valid[gi]   = r_entries[gi].v;
            assign o_entries[gi] = r_entries[gi];
            assign w_hit[gi]     = r_entries[gi].v
                                 && (abs_diff_x(i_qx, r_entries[gi].x) <= LP_RX)
                                 && (abs_diff_y(i_qy, r_entries[gi].y) <= LP_RY);

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_entries[gi] <= '0;
                end else if (w_accept && w_sel[gi]) begin
                    r_entries[gi] <= '{v: 1'b1, x: i_x, y: i_y};
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + (IDW+1)'(1);
        end
    end

    assign o_hit   = |w_hit;
    assign o_count = r_count;

endmodule

// File: rtl/placement_registry.sv
// Setup-time placement registry: nest and sugar-patch tables, lock FSM, sticky
// error flags and a same-cycle collision answer for candidate coordinates.
module placement_registry
    import placement_registry_pkg::*;
#(
    parameter int NEST_R  = 2,
    parameter int PATCH_R = 3
) (
    input  logic                               setup_clk,
    input  logic                               RESET_SIM_n,
    input  logic                               SETUP_MODE,
    input  logic                               nest_wr,
    input  logic [NEST_num_bits-1:0]           nest_id,
    input  logic [X_bits-1:0]                  nest_setup_x,
    input  logic [Y_bits-1:0]                  nest_setup_y,
    input  logic                               patch_wr,
    input  logic [SUGARPATCH_num_bits-1:0]     patch_id,
    input  logic [X_bits-1:0]                  patch_setup_x,
    input  logic [Y_bits-1:0]                  patch_setup_y,
    input  logic [X_bits-1:0]                  collide_x,
    input  logic [Y_bits-1:0]                  collide_y,
    output logic                               collision,
    output logic [NEST_num-1:0][X_bits-1:0]    nests_X,
    output logic [NEST_num-1:0][Y_bits-1:0]    nests_Y,
    output logic [NEST_num_bits:0]             nest_count,
    output logic [SUGARPATCH_num_bits:0]       patch_count,
    output logic                               tables_full,
    output logic                               locked,
    output logic [2:0]                         err_o
);

    reg_state_t                      r_state;
    reg_state_t                      w_state_next;
    logic                            r_setup_d;
    logic [2:0]                      r_err;
    logic                            w_lock;
    logic                            w_nest_hit;
    logic                            w_patch_hit;
    logic                            w_oob;
    logic [2:0]                      w_nest_err;
    logic [2:0]                      w_patch_err;
    loc_entry_t [NEST_num-1:0]       w_nest_entries;
    loc_entry_t [SUGARPATCH_num-1:0] w_patch_entries;

    assign w_lock = (r_state == ST_LOCKED);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL:   if (r_setup_d && !SETUP_MODE) w_state_next = ST_LOCKED;
            ST_LOCKED: w_state_next = ST_LOCKED;
            default:   w_state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge setup_clk or negedge RESET_SIM_n) begin
        if (!RESET_SIM_n) begin
            r_state   <= ST_FILL;
            r_setup_d <= 1'b0;
            r_err     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_setup_d <= SETUP_MODE;
            r_err     <= r_err | w_nest_err | w_patch_err;
        end
    end

    placement_registry_loc_table #(
        .N   (NEST_num),
        .IDW (NEST_num_bits),
        .R   (NEST_R)
    ) u_nests (
        .i_clk     (setup_clk),
        .i_rst_n   (RESET_SIM_n),
        .i_lock    (w_lock),
        .i_wr      (nest_wr),
        .i_id      (nest_id),
        .i_x       (nest_setup_x),
        .i_y       (nest_setup_y),
        .i_qx      (collide_x),
        .i_qy      (collide_y),
        .o_hit     (w_nest_hit),
        .o_entries (w_nest_entries),
        .o_count   (nest_count),
        .o_err     (w_nest_err)
    );

    placement_registry_loc_table #(
        .N   (SUGARPATCH_num),
        .IDW (SUGARPATCH_num_bits),
        .R   (PATCH_R)
    ) u_patches (
        .i_clk     (setup_clk),
        .i_rst_n   (RESET_SIM_n),
        .i_lock    (w_lock),
        .i_wr      (patch_wr),
        .i_id      (patch_id),
        .i_x       (patch_setup_x),
        .i_y       (patch_setup_y),
        .i_qx      (collide_x),
        .i_qy      (collide_y),
        .o_hit     (w_patch_hit),
        .o_entries (w_patch_entries),
        .o_count   (patch_count),
        .o_err     (w_patch_err)
    );

    // Off-screen candidates are rejected as if they collided.
    assign w_oob = ({1'b0, collide_x} >= (X_bits+1)'(PIXELS_X))
                || ({1'b0, collide_y} >= (Y_bits+1)'(PIXELS_Y));

    assign collision   = w_oob | w_nest_hit | w_patch_hit;
    assign tables_full = (nest_count  == (NEST_num_bits+1)'(NEST_num))
                      && (patch_count == (SUGARPATCH_num_bits+1)'(SUGARPATCH_num));
    assign locked      = w_lock;
    assign err_o       = r_err;

    genvar gi;
    generate
        for (gi = 0; gi < NEST_num; gi++) begin : g_pack
            assign nests_X[gi] = w_nest_entries[gi].v ? w_nest_entries[gi].x : '0;
            assign nests_Y[gi] = w_nest_entries[gi].v ? w_nest_entries[gi].y : '0;
        end
    endgenerate

endmodule

// File: tb/tb_placement_registry.sv
// Directed scenarios plus randomized fill/lock/reset epochs against a behavioural model.
module tb_placement_registry;
    import placement_registry_pkg::*;

    localparam int NR = 2;
    localparam int PR = 3;

    logic                               setup_clk = 1'b0;
    logic                               RESET_SIM_n = 1'b0;
    logic                               SETUP_MODE = 1'b0;
    logic                               nest_wr = 1'b0;
    logic [NEST_num_bits-1:0]           nest_id = '0;
    logic [X_bits-1:0]                  nest_setup_x = '0;
    logic [Y_bits-1:0]                  nest_setup_y = '0;
    logic                               patch_wr = 1'b0;
    logic [SUGARPATCH_num_bits-1:0]     patch_id = '0;
    logic [X_bits-1:0]                  patch_setup_x = '0;
    logic [Y_bits-1:0]                  patch_setup_y = '0;
    logic [X_bits-1:0]                  collide_x = '0;
    logic [Y_bits-1:0]                  collide_y = '0;
    logic                               collision;
    logic [NEST_num-1:0][X_bits-1:0]    nests_X;
    logic [NEST_num-1:0][Y_bits-1:0]    nests_Y;
    logic [NEST_num_bits:0]             nest_count;
    logic [SUGARPATCH_num_bits:0]       patch_count;
    logic                               tables_full;
    logic                               locked;
    logic [2:0]                         err_o;

    always #5 setup_clk = ~setup_clk;

    placement_registry #(.NEST_R(NR), .PATCH_R(PR)) dut (
        .setup_clk     (setup_clk),
        .RESET_SIM_n   (RESET_SIM_n),
        .SETUP_MODE    (SETUP_MODE),
        .nest_wr       (nest_wr),
        .nest_id       (nest_id),
        .nest_setup_x  (nest_setup_x),
        .nest_setup_y  (nest_setup_y),
        .patch_wr      (patch_wr),
        .patch_id      (patch_id),
        .patch_setup_x (patch_setup_x),
        .patch_setup_y (patch_setup_y),
        .collide_x     (collide_x),
        .collide_y     (collide_y),
        .collision     (collision),
        .nests_X       (nests_X),
        .nests_Y       (nests_Y),
        .nest_count    (nest_count),
        .patch_count   (patch_count),
        .tables_full   (tables_full),
        .locked        (locked),
        .err_o         (err_o)
    );

    int checks = 0;
    int failures = 0;
    int txn = 0;

    // Reference model: plain arrays of what has been committed.
    bit       m_nv [NEST_num];
    int       m_nx [NEST_num];
    int       m_ny [NEST_num];
    bit       m_pv [SUGARPATCH_num];
    int       m_px [SUGARPATCH_num];
    int       m_py [SUGARPATCH_num];
    bit [2:0] m_err;
    bit       m_locked;
    bit       m_prev;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_box(input int a, input int b, input int r);
        return (a - b <= r) && (b - a <= r);
    endfunction

    function automatic bit m_collision(input int qx, input int qy);
        if (qx >= PIXELS_X || qy >= PIXELS_Y) return 1'b1;
        for (int i = 0; i < NEST_num; i++)
            if (m_nv[i] && in_box(qx, m_nx[i], NR) && in_box(qy, m_ny[i], NR)) return 1'b1;
        for (int i = 0; i < SUGARPATCH_num; i++)
            if (m_pv[i] && in_box(qx, m_px[i], PR) && in_box(qy, m_py[i], PR)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NEST_num; i++) begin m_nv[i] = 0; m_nx[i] = 0; m_ny[i] = 0; end
        for (int i = 0; i < SUGARPATCH_num; i++) begin m_pv[i] = 0; m_px[i] = 0; m_py[i] = 0; end
        m_err = '0;
        m_locked = 0;
        m_prev = 0;
    endtask

    task automatic check_all(input string tag);
        logic [NEST_num-1:0][X_bits-1:0] ex;
        logic [NEST_num-1:0][Y_bits-1:0] ey;
        int nc = 0;
        int pc = 0;
        for (int i = 0; i < NEST_num; i++) begin
            ex[i] = m_nv[i] ? X_bits'(m_nx[i]) : '0;
            ey[i] = m_nv[i] ? Y_bits'(m_ny[i]) : '0;
            nc += int'(m_nv[i]);
        end
        for (int i = 0; i < SUGARPATCH_num; i++) pc += int'(m_pv[i]);
        chk({tag, ".collision"}, 64'(collision), 64'(m_collision(int'(collide_x), int'(collide_y))));
        chk({tag, ".nests_X"}, 64'(nests_X), 64'(ex));
        chk({tag, ".nests_Y"}, 64'(nests_Y), 64'(ey));
        chk({tag, ".nest_count"}, 64'(nest_count), 64'(nc));
        chk({tag, ".patch_count"}, 64'(patch_count), 64'(pc));
        chk({tag, ".tables_full"}, 64'(tables_full), 64'(nc == NEST_num && pc == SUGARPATCH_num));
        chk({tag, ".locked"}, 64'(locked), 64'(m_locked));
        chk({tag, ".err_o"}, 64'(err_o), 64'(m_err));
    endtask

    task automatic model_commit();
        if (m_locked) begin
            if (nest_wr || patch_wr) m_err[2] = 1'b1;
        end else begin
            if (nest_wr) begin
                if (int'(nest_id) >= NEST_num) m_err[1] = 1'b1;
                else if (m_nv[nest_id]) m_err[0] = 1'b1;
                else begin
                    m_nv[nest_id] = 1'b1;
                    m_nx[nest_id] = int'(nest_setup_x);
                    m_ny[nest_id] = int'(nest_setup_y);
                end
            end
            if (patch_wr) begin
                if (int'(patch_id) >= SUGARPATCH_num) m_err[1] = 1'b1;
                else if (m_pv[patch_id]) m_err[0] = 1'b1;
                else begin
                    m_pv[patch_id] = 1'b1;
                    m_px[patch_id] = int'(patch_setup_x);
                    m_py[patch_id] = int'(patch_setup_y);
                end
            end
        end
        if (m_prev && !SETUP_MODE) m_locked = 1'b1;
        m_prev = SETUP_MODE;
    endtask

    // One clock: check at the falling edge, commit the model at the rising edge.
    task automatic step(input string tag);
        @(negedge setup_clk);
        check_all(tag);
        $display("txn %0d %s nw=%0b id=%0d (%0d,%0d) pw=%0b id=%0d (%0d,%0d) q=(%0d,%0d) coll=%0b err=%03b",
                 txn, tag, nest_wr, nest_id, nest_setup_x, nest_setup_y, patch_wr, patch_id,
                 patch_setup_x, patch_setup_y, collide_x, collide_y, collision, err_o);
        txn++;
        @(posedge setup_clk);
        model_commit();
        #1;
        nest_wr = 1'b0;
        patch_wr = 1'b0;
    endtask

    task automatic set_q(input int x, input int y);
        collide_x = X_bits'(x);
        collide_y = Y_bits'(y);
        #1;
    endtask

    task automatic wr_nest(input int id, input int x, input int y);
        nest_wr = 1'b1; nest_id = NEST_num_bits'(id);
        nest_setup_x = X_bits'(x); nest_setup_y = Y_bits'(y);
    endtask

    task automatic wr_patch(input int id, input int x, input int y);
        patch_wr = 1'b1; patch_id = SUGARPATCH_num_bits'(id);
        patch_setup_x = X_bits'(x); patch_setup_y = Y_bits'(y);
    endtask

    task automatic do_reset();
        nest_wr = 1'b0; patch_wr = 1'b0; SETUP_MODE = 1'b1;
        RESET_SIM_n = 1'b0;
        model_clear();
        repeat (2) @(posedge setup_clk);
        #1;
        check_all("reset");
        @(negedge setup_clk);
        RESET_SIM_n = 1'b1;
        @(posedge setup_clk);
        model_commit();
        #1;
    endtask

    // Asynchronous reset asserted between clock edges with entries present.
    task automatic mid_reset();
        int qx = m_nv[0] ? m_nx[0] : 10;
        int qy = m_nv[0] ? m_ny[0] : 10;
        nest_wr = 1'b0; patch_wr = 1'b0;
        set_q(qx, qy);
        RESET_SIM_n = 1'b0;
        #1;
        chk("mid_rst.collision", 64'(collision), 64'(0));
        chk("mid_rst.nest_count", 64'(nest_count), 64'(0));
        chk("mid_rst.patch_count", 64'(patch_count), 64'(0));
        chk("mid_rst.nests_X", 64'(nests_X), 64'(0));
        chk("mid_rst.nests_Y", 64'(nests_Y), 64'(0));
        chk("mid_rst.err_o", 64'(err_o), 64'(0));
        chk("mid_rst.locked", 64'(locked), 64'(0));
        model_clear();
        @(negedge setup_clk);
        RESET_SIM_n = 1'b1;
        @(posedge setup_clk);
        model_commit();
        #1;
    endtask

    task automatic rand_query();
        int r = int'($urandom_range(0, 9));
        int bx, by, off;
        if (r == 0) begin
            set_q(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end else begin
            if (r < 5) begin
                int i = int'($urandom_range(0, NEST_num - 1));
                bx = m_nx[i]; by = m_ny[i]; off = NR + 1;
            end else begin
                int i = int'($urandom_range(0, SUGARPATCH_num - 1));
                bx = m_px[i]; by = m_py[i]; off = PR + 1;
            end
            bx = bx + int'($urandom_range(0, 2 * off)) - off;
            by = by + int'($urandom_range(0, 2 * off)) - off;
            set_q(bx < 0 ? 0 : (bx > 255 ? 255 : bx), by < 0 ? 0 : (by > 255 ? 255 : by));
        end
    endtask

    initial begin
        model_clear();
        do_reset();

        // Nest exclusion box
        set_q(10, 10);
        chk("t1_empty", 64'(collision), 64'(0));
        wr_nest(0, 10, 10);
        step("t1_wr");
        set_q(12, 8);
        chk("t1_hit_edge", 64'(collision), 64'(1));
        set_q(13, 10);
        chk("t1_miss", 64'(collision), 64'(0));
        chk("t1_nestsX0", 64'(nests_X[0]), 64'(10));
        chk("t1_count", 64'(nest_count), 64'(1));

        // Patch exclusion box
        wr_patch(1, 50, 40);
        step("t2_wr");
        set_q(53, 43);
        chk("t2_hit_corner", 64'(collision), 64'(1));
        set_q(54, 40);
        chk("t2_miss", 64'(collision), 64'(0));
        chk("t2_pcount", 64'(patch_count), 64'(1));
        chk("t2_ncount", 64'(nest_count), 64'(1));

        // Duplicate and out-of-range writes
        wr_nest(0, 90, 90);
        step("t3_dup");
        chk("t3_keep", 64'(nests_X[0]), 64'(10));
        chk("t3_err_dup", 64'(err_o), 64'(3'b001));
        wr_nest(NEST_num, 20, 20);
        step("t3_bad");
        chk("t3_err_bad", 64'(err_o), 64'(3'b011));

        // No same-cycle bypass
        wr_nest(2, 30, 30);
        set_q(30, 30);
        chk("t5_same_cycle", 64'(collision), 64'(0));
        step("t5_wr");
        chk("t5_next_cycle", 64'(collision), 64'(1));

        // Fill, lock, late write
        wr_nest(1, 100, 20);
        wr_patch(0, 5, 100);
        step("t4_fill_a");
        wr_patch(2, 150, 110);
        step("t4_fill_b");
        chk("t4_full", 64'(tables_full), 64'(1));
        chk("t4_unlocked", 64'(locked), 64'(0));
        SETUP_MODE = 1'b0;
        step("t4_drop");
        chk("t4_locked", 64'(locked), 64'(1));
        SETUP_MODE = 1'b1;
        wr_patch(0, 70, 70);
        set_q(70, 70);
        step("t4_late");
        chk("t4_late_err", 64'(err_o[2]), 64'(1));
        chk("t4_still_locked", 64'(locked), 64'(1));
        chk("t4_late_ignored", 64'(collision), 64'(0));
        chk("t4_pcount", 64'(patch_count), 64'(SUGARPATCH_num));

        // Randomized epochs with lock, reopen attempt and a mid-fill reset
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                if (ep == 1 && c == 12) mid_reset();
                if (c == 45) SETUP_MODE = 1'b0;
                if (c == 50) SETUP_MODE = 1'b1;
                if ($urandom_range(0, 2) == 0)
                    wr_nest(int'($urandom_range(0, 3)), int'($urandom_range(0, PIXELS_X - 1)),
                            int'($urandom_range(0, PIXELS_Y - 1)));
                if ($urandom_range(0, 2) == 0)
                    wr_patch(int'($urandom_range(0, 3)), int'($urandom_range(0, PIXELS_X - 1)),
                             int'($urandom_range(0, PIXELS_Y - 1)));
                rand_query();
                step("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
